// File: rtl/imem_loader.sv
// Byte-stream instruction image loader; holds the core until the image checksum verifies.
// Optional LOADER_REARM_EN lets a rearm pulse restart loading from DONE/ERR.
module imem_loader #(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(1),
  parameter int              MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              rearm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    LEN_HI, LEN_LO, DATA, CHK, DONE, ERR
  } state_t;

  localparam logic [16:0] MAXW = 17'(MAX_WORDS);

  state_t            state, state_n;
  logic [7:0]        len_hi;
  logic [15:0]       nlen;
  logic [7:0]        csum;
  logic [1:0]        bidx;
  logic [23:0]       wsh;
  logic [ADDR_W-1:0] nxt_addr;
  logic              acc;
  logic              rearm_go;
  logic [15:0]       len_n;
  logic              word_end;

  assign acc      = in_valid && in_ready;
  assign len_n    = {len_hi, in_data};
  assign word_end = (state == DATA) && acc && (bidx == 2'd3);

`ifdef LOADER_REARM_EN
  assign rearm_go = rearm && (state == DONE || state == ERR);
`else
  logic unused_rearm;
  assign unused_rearm = rearm;
  assign rearm_go     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= LEN_HI;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      LEN_HI: if (acc) state_n = LEN_LO;
      LEN_LO: begin
        if (acc) begin
          if (len_n == 16'd0)            state_n = CHK;
          else if ({1'b0, len_n} > MAXW) state_n = ERR;
          else                           state_n = DATA;
        end
      end
      DATA: begin
        if (word_end && words_loaded == nlen - 16'd1)
          state_n = CHK;
      end
      CHK: begin
        if (acc) state_n = (in_data == csum) ? DONE : ERR;
      end
      DONE, ERR: if (rearm_go) state_n = LEN_HI;
      default: state_n = LEN_HI;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    unique case (state)
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ERR:     error    = 1'b1;
      default: in_ready = 1'b1;
    endcase
  end

  // Datapath; the write strobe is registered so it lands the cycle after byte 4.
  always_ff @(posedge clk) begin
    if (rst || rearm_go) begin
      mem_we       <= 1'b0;
      mem_addr     <= BASE_ADDR;
      mem_wdata    <= '0;
      words_loaded <= '0;
      csum         <= '0;
      bidx         <= '0;
      wsh          <= '0;
      len_hi       <= '0;
      nlen         <= '0;
      nxt_addr     <= BASE_ADDR;
    end else begin
      mem_we <= 1'b0;
      if (acc && state != CHK) csum <= csum + in_data;
      if (acc && state == LEN_HI) len_hi <= in_data;
      if (acc && state == LEN_LO) nlen <= len_n;
      if (acc && state == DATA) begin
        bidx <= bidx + 2'd1;
        wsh  <= {wsh[15:0], in_data};
      end
      if (word_end) begin
        mem_we       <= 1'b1;
        mem_addr     <= nxt_addr;
        mem_wdata    <= {wsh, in_data};
        nxt_addr     <= nxt_addr + ADDR_STEP;
        words_loaded <= words_loaded + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader.
// Frame model parses byte lists by the framing rules and predicts writes and final status.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        rearm = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];

  imem_loader dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rearm(rearm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next predicted write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_a.size() == 0) begin
        chk("unexpected_write", {32'd0, mem_addr}, 64'hFFFF_FFFF);
      end else begin
        chk("write_addr", {32'd0, mem_addr}, {32'd0, exp_a.pop_front()});
        chk("write_data", {32'd0, mem_wdata}, {32'd0, exp_d.pop_front()});
      end
    end
  end

  // st: 0 = incomplete, 1 = done, 2 = error
  function automatic void model(input logic [7:0] b[$],
                                output int st, output int wl);
    int n, sum, idx;
    logic [31:0] w;
    st = 0;
    wl = 0;
    if (b.size() < 2) return;
    n = b[0] * 256 + b[1];
    if (n > 1024) begin
      st = 2;
      return;
    end
    sum = b[0] + b[1];
    for (int k = 0; k < n; k++) begin
      idx = 2 + 4 * k;
      if (idx + 3 >= b.size()) return;
      w = {b[idx], b[idx+1], b[idx+2], b[idx+3]};
      sum = sum + b[idx] + b[idx+1] + b[idx+2] + b[idx+3];
      exp_a.push_back(32'(k));
      exp_d.push_back(w);
      wl++;
    end
    idx = 2 + 4 * n;
    if (idx >= b.size()) return;
    st = (b[idx] == 8'(sum % 256)) ? 1 : 2;
  endfunction

  function automatic logic [7:0] csum_of(input logic [7:0] b[$]);
    int s = 0;
    foreach (b[i]) s += b[i];
    return 8'(s % 256);
  endfunction

  // mode 0: back to back, 1: idle every other cycle, 2: random gaps
  task automatic send(input logic [7:0] b[$], input int mode);
    int gap;
    foreach (b[i]) begin
      gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
      repeat (gap) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (!in_ready) break;
      in_valid = 1'b1;
      in_data  = b[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic status(input string nm, input int st, input int wl);
    repeat (3) @(negedge clk);
    chk({nm, "_done"},  {63'd0, done},     {63'd0, st == 1});
    chk({nm, "_error"}, {63'd0, error},    {63'd0, st == 2});
    chk({nm, "_hold"},  {63'd0, cpu_hold}, {63'd0, st != 1});
    chk({nm, "_ready"}, {63'd0, in_ready}, {63'd0, st == 0});
    chk({nm, "_words"}, {48'd0, words_loaded}, 64'(wl));
    chk({nm, "_pending"}, 64'(exp_a.size()), 64'd0);
  endtask

  task automatic run(input string nm, input logic [7:0] b[$],
                     input int mode);
    int st, wl;
    model(b, st, wl);
    send(b, mode);
    status(nm, st, wl);
  endtask

  initial begin
    logic [7:0] f[$];
    logic [7:0] c;
    int n;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_hold",  {63'd0, cpu_hold}, 64'd1);
    chk("rst_we",    {63'd0, mem_we},   64'd0);
    chk("rst_addr",  {32'd0, mem_addr}, 64'd0);
    chk("rst_wdata", {32'd0, mem_wdata}, 64'd0);
    chk("rst_done",  {63'd0, done},     64'd0);
    chk("rst_error", {63'd0, error},    64'd0);
    chk("rst_words", {48'd0, words_loaded}, 64'd0);

    f = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    f.push_back(csum_of(f));
    run("one_word", f, 0);

    do_reset();
    f = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
          8'h55, 8'h66, 8'h77, 8'h88};
    f.push_back(csum_of(f));
    run("two_word_gaps", f, 1);

    do_reset();
    f = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
    run("bad_csum", f, 0);

    do_reset();
    f = '{8'h04, 8'h01, 8'hAA, 8'hBB, 8'hCC};
    run("too_long", f, 0);

    do_reset();
    f = '{8'h00, 8'h01, 8'hDE, 8'hAD};
    send(f, 0);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    f = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    f.push_back(csum_of(f));
    run("abort_restart", f, 0);

    for (int it = 0; it < 20; it++) begin
      do_reset();
      f = {};
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1025, 3000))
                                       : int'($urandom_range(0, 6));
      f.push_back(8'(n / 256));
      f.push_back(8'(n % 256));
      if (n <= 6)
        for (int k = 0; k < 4 * n; k++) f.push_back(8'($urandom));
      c = csum_of(f);
      if ($urandom_range(0, 3) == 0) c = c + 8'($urandom_range(1, 255));
      f.push_back(c);
      run("random", f, 2);
    end

    do_reset();
    f = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    f.push_back(csum_of(f));
    run("pre_rearm", f, 0);
    @(negedge clk);
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
    @(negedge clk);
`ifdef LOADER_REARM_EN
    chk("rearm_done",  {63'd0, done},     64'd0);
    chk("rearm_hold",  {63'd0, cpu_hold}, 64'd1);
    chk("rearm_words", {48'd0, words_loaded}, 64'd0);
    f = '{8'h00, 8'h00, 8'h00};
    run("rearm_empty", f, 0);
`else
    chk("rearm_ign_done",  {63'd0, done},     64'd1);
    chk("rearm_ign_hold",  {63'd0, cpu_hold}, 64'd0);
    chk("rearm_ign_words", {48'd0, words_loaded}, 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
